// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and defaults for the PPU write scheduler
package ppu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    localparam int unsigned        PPU_ADDR_W           = 12;
    localparam int unsigned        PPU_DATA_W           = 32;
    localparam logic [11:0]        IRQ_ACK_ADDR_DEFAULT = 12'hFFF;

    typedef struct packed {
        logic [PPU_ADDR_W-1:0] addr;
        logic [PPU_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty/count
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full/empty come from registered state, so a pop never frees room for a same-cycle push.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ppu_write_scheduler.sv
// rtl/ppu_write_scheduler.sv - queues CPU writes, replays them during vblank, raises frame irq
// Optional drop statistics counter: PPU_WSCHED_DROP_STATS_EN.
module ppu_write_scheduler
    import ppu_pkg::*;
#(
    parameter int                DEPTH        = 16,
    parameter int                ADDR_W       = 12,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] IRQ_ACK_ADDR = IRQ_ACK_ADDR_DEFAULT[ADDR_W-1:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     vblank,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_write_data,
    output logic                     irq,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int EW = ADDR_W + DATA_W;

    sched_state_e      state_q, state_d;
    logic              vblank_q;
    logic              irq_q, irq_d;
    logic              overflow_q, overflow_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    logic              wr_req, ack, push_req, push_acc, drop, pop;
    logic              fifo_full, fifo_empty, empty_after;
    logic [EW-1:0]     fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_cnt;

    assign wr_req   = chipselect && write;
    assign ack      = wr_req && (address == IRQ_ACK_ADDR);
    assign push_req = wr_req && (address != IRQ_ACK_ADDR);
    assign push_acc = push_req && !fifo_full;
    assign drop     = push_req && fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .wdata_i ({address, write_data}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign empty_after = fifo_empty ||
                         (fifo_cnt == ($clog2(DEPTH)+1)'(1) && pop && !push_acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (vblank && !fifo_empty) state_d = ST_DRAIN;
                else if (vblank)           state_d = ST_DONE;
            end
            ST_DRAIN: begin
                if (!vblank)          state_d = ST_IDLE;
                else if (empty_after) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!vblank)          state_d = ST_IDLE;
                else if (!fifo_empty) state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IDLE/DONE pop on the edge that enters DRAIN so the first strobe follows its push by one cycle.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_DRAIN:         pop = vblank && !fifo_empty;
            ST_IDLE, ST_DONE: pop = vblank && !fifo_empty;
            default:          pop = 1'b0;
        endcase
        mem_write_d = pop;
        mem_addr_d  = pop ? fifo_rdata[EW-1:DATA_W] : mem_addr_q;
        mem_data_d  = pop ? fifo_rdata[DATA_W-1:0]  : mem_data_q;
    end

    always_comb begin
        irq_d      = irq_q;
        overflow_d = overflow_q;
        if (ack)                  irq_d = 1'b0;
        if (vblank && !vblank_q)  irq_d = 1'b1;
        if (ack)                  overflow_d = 1'b0;
        if (drop)                 overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_q    <= 1'b0;
            irq_q       <= 1'b0;
            overflow_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            vblank_q    <= vblank;
            irq_q       <= irq_d;
            overflow_q  <= overflow_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

`ifdef PPU_WSCHED_DROP_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ack)                                drop_cnt_d = {15'd0, drop};
        else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'd0;
`endif

    assign mem_write      = mem_write_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_data_q;
    assign irq            = irq_q;
    assign overflow       = overflow_q;
    assign fifo_count     = fifo_cnt;

endmodule

// File: tb/tb_ppu_write_scheduler.sv
// tb/tb_ppu_write_scheduler.sv - bench for ppu_write_scheduler with queue-based reference model
module tb_ppu_write_scheduler;
    import ppu_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [11:0] address = 12'd0;
    logic [31:0] write_data = 32'd0;
    logic        vblank = 1'b0;
    logic        mem_write;
    logic [11:0] mem_address;
    logic [31:0] mem_write_data;
    logic        irq;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_fail = 0;

    ppu_write_scheduler #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .chipselect     (chipselect),
        .write          (write),
        .address        (address),
        .write_data     (write_data),
        .vblank         (vblank),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .irq            (irq),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending writes plus the sticky flags.
    wr_entry_t   mq[$];
    logic        m_mw = 0;
    logic [11:0] m_addr = 0;
    logic [31:0] m_data = 0;
    logic        m_irq = 0, m_ov = 0, m_vbq = 0;
    logic [15:0] m_drops = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_mw = 0; m_addr = 0; m_data = 0;
            m_irq = 0; m_ov = 0; m_vbq = 0; m_drops = 0;
        end else begin
            logic is_ack, is_push, fits;
            wr_entry_t e;
            is_ack  = chipselect && write && address == 12'hFFF;
            is_push = chipselect && write && address != 12'hFFF;
            fits    = mq.size() < DEPTH;
            m_mw = 0;
            if (vblank && mq.size() > 0) begin
                e = mq.pop_front();
                m_mw = 1; m_addr = e.addr; m_data = e.data;
            end
            if (is_push && fits) begin
                e.addr = address; e.data = write_data;
                mq.push_back(e);
            end
            if (vblank && !m_vbq)  m_irq = 1;
            else if (is_ack)       m_irq = 0;
            if (is_push && !fits)  m_ov = 1;
            else if (is_ack)       m_ov = 0;
            if (is_ack)            m_drops = (is_push && !fits) ? 16'd1 : 16'd0;
            else if (is_push && !fits && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            m_vbq = vblank;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("mem_write", mem_write, m_mw);
            chk("mem_address", mem_address, m_addr);
            chk("mem_write_data", mem_write_data, m_data);
            chk("irq", irq, m_irq);
            chk("fifo_count", fifo_count, mq.size());
            chk("overflow", overflow, m_ov);
`ifdef PPU_WSCHED_DROP_STATS_EN
            chk("drop_count", drop_count, m_drops);
`else
            chk("drop_count", drop_count, 16'd0);
`endif
        end
    end

    // Drive inputs for one edge; returns 1 time unit after that edge.
    task automatic step(input logic cs, input logic wr, input logic [11:0] a,
                        input logic [31:0] d, input logic vb);
        chipselect = cs; write = wr; address = a; write_data = d; vblank = vb;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        chipselect = 0; write = 0; vblank = 0;
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        logic vb;
        do_reset();
        chk("reset_mem_write", mem_write, 1'b0);
        chk("reset_irq", irq, 1'b0);
        chk("reset_count", fifo_count, 5'd0);

        // Test 1: queue two writes outside vblank, then drain them.
        step(1, 1, 12'h001, 32'hA5, 0);
        step(1, 1, 12'h002, 32'h5A, 0);
        chk("t1_count", fifo_count, 5'd2);
        chk("t1_no_strobe", mem_write, 1'b0);
        step(0, 0, 0, 0, 1);
        chk("t1_irq", irq, 1'b1);
        chk("t1_s1", {mem_write, mem_address, mem_write_data}, {1'b1, 12'h001, 32'hA5});
        step(0, 0, 0, 0, 1);
        chk("t1_s2", {mem_write, mem_address, mem_write_data}, {1'b1, 12'h002, 32'h5A});
        step(0, 0, 0, 0, 1);
        chk("t1_end", mem_write, 1'b0);

        // Test 2: overflow then acknowledge.
        for (int i = 0; i < 17; i++) step(1, 1, 12'(i + 16), 32'(i), 0);
        chk("t2_count", fifo_count, 5'd16);
        chk("t2_ov", overflow, 1'b1);
`ifdef PPU_WSCHED_DROP_STATS_EN
        chk("t2_drops", drop_count, 16'd1);
`endif
        step(1, 1, 12'hFFF, 0, 0);
        chk("t2_ack_irq", irq, 1'b0);
        chk("t2_ack_ov", overflow, 1'b0);
        chk("t2_ack_drops", drop_count, 16'd0);
        chk("t2_ack_count", fifo_count, 5'd16);

        // Test 3: partial drain across two vblanks.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, 1, 12'(i), 32'(i * 3), 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 1);
            chk("t3_strobe_a", {mem_write, mem_address}, {1'b1, 12'(i)});
        end
        step(0, 0, 0, 0, 0);
        chk("t3_stop", mem_write, 1'b0);
        chk("t3_count", fifo_count, 5'd5);
        for (int i = 4; i <= 8; i++) begin
            step(0, 0, 0, 0, 1);
            chk("t3_strobe_b", {mem_write, mem_address, mem_write_data}, {1'b1, 12'(i), 32'(i * 3)});
        end
        step(0, 0, 0, 0, 1);
        chk("t3_empty", fifo_count, 5'd0);

        // Test 4: single-write latency during vblank.
        step(1, 1, 12'h040, 32'h1234, 1);
        chk("t4_edge_n", mem_write, 1'b0);
        step(0, 0, 0, 0, 1);
        chk("t4_edge_n1", {mem_write, mem_address, mem_write_data}, {1'b1, 12'h040, 32'h1234});

        // Test 5: ack coinciding with vblank rise.
        step(1, 1, 12'hFFF, 0, 0);
        chk("t5_cleared", irq, 1'b0);
        step(1, 1, 12'hFFF, 0, 1);
        chk("t5_set_wins", irq, 1'b1);

        // Test 6: reset during a drain.
        for (int i = 0; i < 6; i++) step(1, 1, 12'(i + 100), 32'(i), 0);
        step(0, 0, 0, 0, 1);
        chk("t6_draining", mem_write, 1'b1);
        #2 reset = 1;
        #1;
        chk("t6_rst_outs", {mem_write, mem_address, mem_write_data, irq, overflow},
            {1'b0, 12'd0, 32'd0, 1'b0, 1'b0});
        chk("t6_rst_count", fifo_count, 5'd0);
        @(posedge clk); #1;
        reset = 0;
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            chk("t6_no_strobe", mem_write, 1'b0);
        end

        // Randomized traffic against the model.
        vb = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            logic        cs;
            if ($urandom_range(0, 19) == 0) vb = ~vb;
            a = 12'($urandom);
            if (a == 12'hFFF) a = 12'hFFE;
            if ($urandom_range(0, 15) == 0) a = 12'hFFF;
            cs = ($urandom_range(0, 2) != 0);
            step(cs, 1'($urandom), a, $urandom, vb);
        end
        step(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
